ring_anim_sequencer: RTL and testbench
======================================

RING_ANIM_SEQUENCER -- requirements
Module: ring_anim_sequencer

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 256: frame_ticks spent in each auto-demo state, legal range 2..1024.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port frame_tick, input, 1: one-cycle pulse at frame origin (hpos==0, vpos==0).
REQ-005 SHALL have port auto_en, input, 1: 1 selects auto-demo sequencing, 0 selects manual controls.
REQ-006 SHALL have ports man_speed, man_dir, man_pause, man_gray, input, 1 each: manual speed (1=fast), direction (1=inward), pause, grayscale.
REQ-007 SHALL have port step_req, input, 1: level from a button; each rising edge requests one single-frame step while paused.
REQ-008 SHALL have port frame, output, 10: animation frame counter.
REQ-009 SHALL have ports dir_out and gray_out, output, 1 each: direction and grayscale applied to the ring datapath.
REQ-010 SHALL have port seq_state, output, 3: current sequencer state encoding.

Function
REQ-011 States SHALL be: MANUAL=0, OUT_SLOW=1, OUT_FAST=2, IN_FAST=3, IN_SLOW=4, GRAY_HOLD=5; codes 6..7 unused and SHALL recover to MANUAL on the next frame_tick.
REQ-012 All state, setting and counter updates SHALL occur only in cycles with frame_tick=1 (tear-free), except step edge capture (REQ-018).
REQ-013 On a frame_tick, frame SHALL advance using settings in effect before that tick; new settings latch in the same cycle and first affect the following tick.
REQ-014 Effective settings per state: MANUAL = man_* inputs sampled at the tick; OUT_SLOW speed0 dir0; OUT_FAST speed1 dir0; IN_FAST speed1 dir1; IN_SLOW speed0 dir1; GRAY_HOLD speed0 dir0 gray1; auto states never paused; gray=0 in all auto states except GRAY_HOLD.
REQ-015 Frame increment: +1 at speed 0, +2 at speed 1, modulo 1024 (1023+1 -> 0, 1023+2 -> 1, 1022+2 -> 0).
REQ-016 Dwell counter (10 bits) SHALL count frame_ticks in auto states; on a tick with count==DWELL_FRAMES-1 the state SHALL advance OUT_SLOW->OUT_FAST->IN_FAST->IN_SLOW->GRAY_HOLD->OUT_SLOW and count SHALL clear to 0.
REQ-017 auto_en sampled at tick: MANUAL with auto_en=1 -> OUT_SLOW, count 0; any auto state with auto_en=0 -> MANUAL, count 0; auto_en toggles between ticks SHALL have no effect.
REQ-018 step_req SHALL be registered once per clk; a 0->1 transition SHALL set step_pending; further edges while pending SHALL be ignored (no queueing beyond one).
REQ-019 In MANUAL with pause active, a tick with step_pending=1 SHALL advance frame by exactly 1 (independent of speed) and clear step_pending; without step_pending, frame SHALL hold.
REQ-020 Edge capture and tick in the same cycle: the step SHALL apply on the next tick, not the current one.
REQ-021 step_pending SHALL be cleared on any tick where not paused or in an auto state (no stale step).
REQ-022 dir_out, gray_out, seq_state SHALL be registered outputs changing only on tick cycles.

Reset
REQ-023 rst_n low SHALL asynchronously force frame=0, dir_out=0, gray_out=0, seq_state=MANUAL, internal speed=0, dwell count=0, step_pending=0, step history register=0.
REQ-024 Reset mid-sequence SHALL abort immediately; after release the block SHALL resume from MANUAL on the next tick.

Verification (DWELL_FRAMES=4)
REQ-025 Manual, speed0, 5 ticks -> frame 0,1,2,3,4,5; then man_speed=1 at tick 6 -> frame 6 at tick 6, 8 at tick 7 (one-tick latency).
REQ-026 Wrap: frame preset to 1022 via stepping, speed1, one tick -> frame 0; next tick -> 2.
REQ-027 auto_en=1 from reset, 22 ticks -> seq_state sequence 0,1,1,1,1,2,2,2,2,3,...,5,5,5,5,1; gray_out=1 only during state 5; dir_out=1 only during states 3,4.
REQ-028 Paused manual, two step_req edges between ticks then 3 ticks -> frame advances exactly 1 total; edge coinciding with tick -> applied at following tick.
REQ-029 auto_en dropped during IN_FAST, then raised -> MANUAL at next tick, then OUT_SLOW with dwell restarted (4 full ticks before OUT_FAST).
REQ-030 rst_n pulsed low asynchronously mid-GRAY_HOLD (no clk edge) -> outputs all 0, seq_state=0 immediately.

Source files
------------

// File: rtl/ring_anim_sequencer.sv
// ring_anim_sequencer
//   Frame-rate animation sequencer for the ring renderer. Advances a 10-bit
//   frame counter once per frame_tick and selects direction/grayscale either
//   from manual controls or from a fixed auto-demo cycle. Every update
//   (except capturing a step button edge) happens only on frame_tick cycles,
//   so the datapath never sees settings change mid-frame.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   frame_tick         one-cycle pulse at frame origin
//   auto_en            1 = auto-demo sequence, 0 = manual controls
//   man_speed/dir/pause/gray  manual settings, sampled on frame_tick
//   step_req           button level; each rising edge requests one step
//                      while paused
//   frame              animation frame counter (mod 1024)
//   dir_out, gray_out  direction / grayscale applied to the ring datapath
//   seq_state          current sequencer state (see state_t)
//
// Handshake note: frame_tick is a strobe with no backpressure. Settings
// latched on a tick govern the frame increment of the following tick.
module ring_anim_sequencer #(
  parameter int DWELL_FRAMES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       auto_en,
  input  logic       man_speed,
  input  logic       man_dir,
  input  logic       man_pause,
  input  logic       man_gray,
  input  logic       step_req,
  output logic [9:0] frame,
  output logic       dir_out,
  output logic       gray_out,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    MANUAL    = 3'd0,
    OUT_SLOW  = 3'd1,
    OUT_FAST  = 3'd2,
    IN_FAST   = 3'd3,
    IN_SLOW   = 3'd4,
    GRAY_HOLD = 3'd5
  } state_t;

  localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);

  state_t     state;
  logic [9:0] dwell_cnt;
  logic       speed_q;
  logic       pause_q;
  logic       step_q;
  logic       step_pending;

  state_t     next_state;
  logic [9:0] next_cnt;
  logic       next_speed;
  logic       next_dir;
  logic       next_pause;
  logic       next_gray;
  logic       step_edge;
  logic       paused;
  logic [9:0] frame_inc;

  assign seq_state = state;

  always_comb begin
    step_edge = step_req & ~step_q;
    paused    = (state == MANUAL) && pause_q;

    // Increment uses the settings latched on the previous tick.
    if (paused) frame_inc = step_pending ? 10'd1 : 10'd0;
    else        frame_inc = speed_q ? 10'd2 : 10'd1;

    next_state = state;
    next_cnt   = 10'd0;
    case (state)
      MANUAL: next_state = auto_en ? OUT_SLOW : MANUAL;
      OUT_SLOW, OUT_FAST, IN_FAST, IN_SLOW, GRAY_HOLD: begin
        if (!auto_en) begin
          next_state = MANUAL;
        end else if (dwell_cnt == DWELL_LAST) begin
          case (state)
            OUT_SLOW: next_state = OUT_FAST;
            OUT_FAST: next_state = IN_FAST;
            IN_FAST:  next_state = IN_SLOW;
            IN_SLOW:  next_state = GRAY_HOLD;
            default:  next_state = OUT_SLOW;
          endcase
        end else begin
          next_cnt = dwell_cnt + 10'd1;
        end
      end
      default: next_state = MANUAL;  // unused codes recover
    endcase

    // Settings belong to the state being entered, so outputs and seq_state
    // always agree.
    next_speed = 1'b0;
    next_dir   = 1'b0;
    next_pause = 1'b0;
    next_gray  = 1'b0;
    case (next_state)
      MANUAL: begin
        next_speed = man_speed;
        next_dir   = man_dir;
        next_pause = man_pause;
        next_gray  = man_gray;
      end
      OUT_FAST: next_speed = 1'b1;
      IN_FAST: begin
        next_speed = 1'b1;
        next_dir   = 1'b1;
      end
      IN_SLOW:   next_dir  = 1'b1;
      GRAY_HOLD: next_gray = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MANUAL;
      dwell_cnt    <= 10'd0;
      frame        <= 10'd0;
      speed_q      <= 1'b0;
      pause_q      <= 1'b0;
      dir_out      <= 1'b0;
      gray_out     <= 1'b0;
      step_q       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      step_q <= step_req;
      if (frame_tick) begin
        frame     <= frame + frame_inc;
        state     <= next_state;
        dwell_cnt <= next_cnt;
        speed_q   <= next_speed;
        pause_q   <= next_pause;
        dir_out   <= next_dir;
        gray_out  <= next_gray;
        // Only a paused tick with nothing pending may capture an edge seen
        // in this same cycle; it is then consumed on the following tick.
        // Every other tick leaves no step outstanding.
        step_pending <= (paused && !step_pending) ? step_edge : 1'b0;
      end else if (step_edge) begin
        step_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_anim_sequencer.sv
module tb_ring_anim_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       auto_en = 1'b0;
  logic       man_speed = 1'b0;
  logic       man_dir = 1'b0;
  logic       man_pause = 1'b0;
  logic       man_gray = 1'b0;
  logic       step_req = 1'b0;
  logic [9:0] frame;
  logic       dir_out;
  logic       gray_out;
  logic [2:0] seq_state;

  ring_anim_sequencer #(.DWELL_FRAMES(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .auto_en    (auto_en),
    .man_speed  (man_speed),
    .man_dir    (man_dir),
    .man_pause  (man_pause),
    .man_gray   (man_gray),
    .step_req   (step_req),
    .frame      (frame),
    .dir_out    (dir_out),
    .gray_out   (gray_out),
    .seq_state  (seq_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];

  // reference model state
  int m_state, m_frame, m_cnt;
  bit m_speed, m_dir, m_gray, m_pause, m_pend, m_hist;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_frame = 0; m_cnt = 0;
    m_speed = 0; m_dir = 0; m_gray = 0; m_pause = 0; m_pend = 0; m_hist = 0;
  endtask

  function automatic logic [14:0] model_pack();
    return {m_state[2:0], m_frame[9:0], m_dir, m_gray};
  endfunction

  // What the block should do at the coming rising edge, given current inputs.
  task automatic model_edge();
    bit edge_now, hold;
    int nxt;
    edge_now = step_req && !m_hist;
    m_hist = step_req;
    if (frame_tick) begin
      hold = (m_state == 0) && m_pause;
      if (!hold)      m_frame = (m_frame + (m_speed ? 2 : 1)) % 1024;
      else if (m_pend) m_frame = (m_frame + 1) % 1024;
      m_pend = hold && !m_pend && edge_now;
      if (m_state == 0) begin
        nxt = auto_en ? 1 : 0; m_cnt = 0;
      end else if (!auto_en) begin
        nxt = 0; m_cnt = 0;
      end else if (m_cnt == DWELL - 1) begin
        nxt = (m_state == 5) ? 1 : m_state + 1; m_cnt = 0;
      end else begin
        nxt = m_state; m_cnt = m_cnt + 1;
      end
      m_state = nxt;
      m_speed = 0; m_dir = 0; m_pause = 0; m_gray = 0;
      case (nxt)
        0: begin m_speed = man_speed; m_dir = man_dir; m_pause = man_pause; m_gray = man_gray; end
        2: m_speed = 1;
        3: begin m_speed = 1; m_dir = 1; end
        4: m_dir = 1;
        5: m_gray = 1;
        default: ;
      endcase
    end else if (edge_now) begin
      m_pend = 1;
    end
  endtask

  // driver: one clock cycle, tick or not; scoreboard compare after the edge
  task automatic cyc(input bit tick);
    logic [14:0] e;
    @(negedge clk);
    frame_tick = tick;
    model_edge();
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", {17'd0, seq_state, frame, dir_out, gray_out}, {17'd0, e});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0;
    step_req = 1'b0;
    model_reset();
    #1;
    check("rst_state", seq_state, 0);
    check("rst_frame", frame, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq_exp[22] = '{0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,5,5,5,5,1};

  initial begin
    model_reset();
    #12;
    check("rst_state", seq_state, 0);
    check("rst_frame", frame, 0);
    check("rst_dir", dir_out, 0);
    check("rst_gray", gray_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // manual speed 0, then one-tick latency on speed change
    for (int i = 1; i <= 5; i++) begin
      cyc(0); cyc(1);
      check("man_s0", frame, i);
    end
    man_speed = 1'b1;
    cyc(0); cyc(1);
    check("speed_lat0", frame, 6);
    cyc(1);
    check("speed_lat1", frame, 8);

    // wrap at speed 1
    repeat (507) cyc(1);
    check("wrap_pre", frame, 1022);
    cyc(1);
    check("wrap_0", frame, 0);
    cyc(1);
    check("wrap_2", frame, 2);

    // pause and single stepping
    man_pause = 1'b1;
    cyc(1);
    check("pause_latch", frame, 4);
    step_req = 1'b1; cyc(0);
    step_req = 1'b0; cyc(0);
    step_req = 1'b1; cyc(0);
    step_req = 1'b0; cyc(0);
    cyc(1); cyc(1); cyc(1);
    check("step_once", frame, 5);
    step_req = 1'b1; cyc(1);
    check("step_coinc_hold", frame, 5);
    step_req = 1'b0; cyc(0);
    cyc(1);
    check("step_coinc_next", frame, 6);
    cyc(1);
    check("step_no_repeat", frame, 6);

    // a pending step is dropped by an unpaused tick
    man_pause = 1'b0;
    cyc(1);
    check("unpause_hold", frame, 6);
    step_req = 1'b1; cyc(0);
    step_req = 1'b0; cyc(1);
    check("unpaused_run", frame, 8);
    man_pause = 1'b1;
    cyc(1);
    check("repause", frame, 10);
    cyc(1);
    check("stale_cleared", frame, 10);

    // random manual activity
    repeat (300) begin
      man_speed = 1'($urandom_range(1));
      man_dir   = 1'($urandom_range(1));
      man_pause = 1'($urandom_range(1));
      man_gray  = 1'($urandom_range(1));
      step_req  = 1'($urandom_range(1));
      cyc(1'($urandom_range(2) == 0));
    end

    // auto-demo sequence from reset
    do_reset();
    man_speed = 0; man_dir = 0; man_pause = 0; man_gray = 0;
    auto_en = 1'b1;
    check("auto_seq0", seq_state, seq_exp[0]);
    for (int k = 1; k < 22; k++) begin
      cyc(0); cyc(1);
      check("auto_seq", seq_state, seq_exp[k]);
      check("auto_gray", gray_out, (seq_exp[k] == 5) ? 1 : 0);
      check("auto_dir", dir_out, (seq_exp[k] == 3 || seq_exp[k] == 4) ? 1 : 0);
    end

    // drop auto_en in IN_FAST, raise again: dwell restarts
    do_reset();
    auto_en = 1'b1;
    repeat (9) cyc(1);
    check("in_fast", seq_state, 3);
    auto_en = 1'b0;
    cyc(1);
    check("drop_manual", seq_state, 0);
    auto_en = 1'b1;
    cyc(1);
    check("reenter", seq_state, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("dwell_restart", seq_state, 1);
    end
    cyc(1);
    check("dwell_done", seq_state, 2);
    auto_en = 1'b0; cyc(0);
    auto_en = 1'b1; cyc(1);
    check("auto_glitch", seq_state, 2);

    // asynchronous reset in GRAY_HOLD
    do_reset();
    auto_en = 1'b1;
    repeat (17) cyc(1);
    check("gray_hold", seq_state, 5);
    check("gray_hold_g", gray_out, 1);
    cyc(1); cyc(1);
    frame_tick = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", seq_state, 0);
    check("async_frame", frame, 0);
    check("async_gray", gray_out, 0);
    check("async_dir", dir_out, 0);
    step_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    auto_en = 1'b0;
    cyc(1);
    check("post_rst_state", seq_state, 0);
    check("post_rst_frame", frame, 1);

    // random mixed auto/manual activity
    repeat (400) begin
      if ($urandom_range(15) == 0) auto_en = ~auto_en;
      man_speed = 1'($urandom_range(1));
      man_dir   = 1'($urandom_range(1));
      man_pause = 1'($urandom_range(1));
      man_gray  = 1'($urandom_range(1));
      step_req  = 1'($urandom_range(1));
      cyc(1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
